// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage of the 5-stage MIPS pipeline.
//
// Selects forwarded operands, evaluates the single-cycle ALU, runs an
// iterative multiply/divide unit that owns HI/LO, and holds the EX/MEM
// pipeline register that the forwarding unit compares against.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   fa, fb                   operand selects: 00 ID/EX, 10 EX/MEM result,
//                            01 MEM/WB data, 11 same as 00
//   id_ex_rs_data/rt_data    register operands from ID/EX
//   id_ex_imm                sign-extended immediate (used when alu_src=1)
//   mem_wb_data              write-back value from MEM/WB
//   alu_src, alu_op          operand B select and ALU function
//   id_ex_rd, id_ex_*        destination and control bits from ID/EX
//   md_start, md_op          launch MULT/MULTU/DIV/DIVU on the current operands
//   flush                    load a bubble into EX/MEM
//   ex_mem_*                 registered EX/MEM outputs
//   hi, lo                   multiply/divide result registers
//   md_busy                  high while the multiply/divide unit is working
//
// MD_CYCLES is the iteration count of the multiply/divide unit and must
// equal WIDTH, since each iteration consumes one operand bit.
module ex_stage_md #(
    parameter int WIDTH     = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       fa,
    input  logic [1:0]       fb,
    input  logic [WIDTH-1:0] id_ex_rs_data,
    input  logic [WIDTH-1:0] id_ex_rt_data,
    input  logic [WIDTH-1:0] id_ex_imm,
    input  logic [WIDTH-1:0] mem_wb_data,
    input  logic             alu_src,
    input  logic [3:0]       alu_op,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_mem_write,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic             flush,
    output logic [WIDTH-1:0] ex_mem_result,
    output logic [WIDTH-1:0] ex_mem_store_data,
    output logic [4:0]       ex_mem_rd,
    output logic             ex_mem_reg_write,
    output logic             ex_mem_mem_read,
    output logic             ex_mem_mem_write,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy
);

    localparam int CW = $clog2(MD_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_t;

    md_state_t        state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] op_a, fwd_b, op_b, alu_result;
    logic [WIDTH-1:0] acc_hi, acc_lo, md_b;
    logic             is_div, is_signed, neg_a, neg_b;
    logic             md_accept, bubble, start_signed;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0] quot_fixed, rem_fixed;

    // Operand forwarding; store data is always the forwarded rt.
    always_comb begin
        case (fa)
            2'b10:   op_a = ex_mem_result;
            2'b01:   op_a = mem_wb_data;
            default: op_a = id_ex_rs_data;
        endcase
        case (fb)
            2'b10:   fwd_b = ex_mem_result;
            2'b01:   fwd_b = mem_wb_data;
            default: fwd_b = id_ex_rt_data;
        endcase
        op_b = alu_src ? id_ex_imm : fwd_b;
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = op_a & op_b;
            4'b0001: alu_result = op_a | op_b;
            4'b0010: alu_result = op_a + op_b;
            4'b0110: alu_result = op_a - op_b;
            4'b0111: alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b1100: alu_result = ~(op_a | op_b);
            4'b1010: alu_result = hi;
            4'b1011: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

    // A start is only taken from IDLE and never in the same cycle as a flush.
    assign md_accept    = md_start && (state == IDLE) && !flush;
    assign bubble       = flush || md_busy || md_accept;
    assign start_signed = ~md_op[0];
    assign mag_a        = (start_signed && op_a[WIDTH-1])  ? -op_a  : op_a;
    assign mag_b        = (start_signed && fwd_b[WIDTH-1]) ? -fwd_b : fwd_b;

    // One iteration: multiply adds the multiplicand when the low bit of the
    // multiplier is set then shifts {acc_hi,acc_lo} right; divide shifts the
    // next dividend bit into the partial remainder and subtracts if it fits.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_b} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, md_b});
        div_diff  = div_shift[WIDTH-1:0] - md_b;
    end

    // Sign fixup. A zero divisor yields an all-ones quotient which is left
    // as is; the remainder then equals the dividend magnitude, and restoring
    // its sign returns the original dividend.
    always_comb begin
        prod_fixed = (is_signed && (neg_a ^ neg_b)) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quot_fixed = (is_signed && (neg_a ^ neg_b) && (md_b != '0)) ? -acc_lo : acc_lo;
        rem_fixed  = (is_signed && neg_a) ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (md_accept) state_next = RUN;
            RUN:     if (count == CW'(MD_CYCLES - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            md_b      <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            md_busy   <= 1'b0;
        end else begin
            md_busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (md_accept) begin
                        count     <= '0;
                        acc_hi    <= '0;
                        acc_lo    <= mag_a;
                        md_b      <= mag_b;
                        is_div    <= md_op[1];
                        is_signed <= start_signed;
                        neg_a     <= start_signed && op_a[WIDTH-1];
                        neg_b     <= start_signed && fwd_b[WIDTH-1];
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    count <= '0;
                    if (is_div) begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            ex_mem_result     <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd         <= '0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
        end else begin
            ex_mem_result     <= alu_result;
            ex_mem_store_data <= fwd_b;
            ex_mem_rd         <= id_ex_rd;
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_read   <= id_ex_mem_read;
            ex_mem_mem_write  <= id_ex_mem_write;
        end
    end

endmodule

// File: doc/ex_stage_md.md
Name: ex_stage_md

Overview:
- Execute stage of the 5-stage MIPS pipeline; sits directly downstream of the forwarding unit and consumes its FA/FB selects.
- Selects forwarded operands, runs the single-cycle ALU and an iterative 32-cycle multiply/divide unit with HI/LO, and owns the EX/MEM pipeline register.
- The EX/MEM register's rd/reg_write outputs are the "mem" address/enable the forwarding unit compares against.

Parameters:
- WIDTH, 32, datapath width.
- MD_CYCLES, 32, iteration count of the multiply/divide FSM; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- fa  in  2  operand A select: 00 ID/EX rs, 10 EX/MEM result, 01 MEM/WB data, 11 treated as 00
- fb  in  2  operand B select, same encoding, applied to rt before the immediate mux
- id_ex_rs_data  in  WIDTH  rs value from ID/EX
- id_ex_rt_data  in  WIDTH  rt value from ID/EX
- id_ex_imm  in  WIDTH  sign-extended immediate
- mem_wb_data  in  WIDTH  write-back data from MEM/WB
- alu_src  in  1  1: operand B = id_ex_imm
- alu_op  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1010 MFHI, 1011 MFLO
- id_ex_rd  in  5  destination register
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write  in  1 each  control bits from ID/EX
- md_start  in  1  launch multiply/divide on the current operands
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- flush  in  1  load a bubble into EX/MEM
- ex_mem_result  out  WIDTH  registered ALU result; also the EX/MEM forward source
- ex_mem_store_data  out  WIDTH  registered forwarded rt value
- ex_mem_rd  out  5  registered destination
- ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write  out  1 each  registered controls
- hi, lo  out  WIDTH  HI/LO registers
- md_busy  out  1  high while the multiply/divide FSM is not IDLE; stalls IF/ID/ID-EX upstream

Behaviour:
- Reset (async, any time including mid-operation): all outputs 0, FSM to IDLE, iteration counter 0, hi=lo=0.
- Operand A is the fa-selected source. Operand B is the fb-selected source, then id_ex_imm if alu_src=1. Store data is always the fb-selected rt.
- ALU latency is 1 cycle: results are captured into EX/MEM at the next rising edge. ADD/SUB wrap modulo 2^WIDTH with no overflow trap. SLT yields 1 or 0. MFHI/MFLO return the current hi/lo.
- Bubble means reg_write=mem_read=mem_write=0, rd=0, result=0, store_data=0.
- EX/MEM loads a bubble when any of these holds: flush=1, md_busy=1, or md_start is accepted that cycle. Otherwise it loads the ID/EX values.
- md_start is accepted only in IDLE with flush=0. md_start while busy or together with flush is ignored.
- FSM states:
  - IDLE, on an accepted start: latch operand magnitudes, signs and op, go to RUN, counter=0.
  - RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After MD_CYCLES steps go to FIX.
  - FIX: apply signs and write hi/lo, go to IDLE.
- md_busy is registered and stays high exactly MD_CYCLES+1 cycles after the accepting edge. hi/lo update on the edge that leaves FIX.
- MULT/MULTU: {hi,lo} = full 64-bit product.
- DIV/DIVU: lo = quotient, hi = remainder. The quotient truncates toward zero and the remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = dividend. Signed divide by zero does not apply sign fixup to lo.
- flush does not abort a running multiply/divide.
- MFHI/MFLO issued while busy are held upstream by the stall and never see partial values.

Test Plan:
- Forwarding mux: fa=10, ex_mem_result=5, fb=01, mem_wb_data=7, alu_op=ADD → ex_mem_result=12 after one edge; fa=fb=00 with rs=3, rt=4 → 7.
- Register pass-through: alu_src=1, imm=0xFFFFFFFF, rs=1, ADD → 0; id_ex_rd=9 with reg_write=1 → ex_mem_rd=9, ex_mem_reg_write=1; assert flush → all EX/MEM outputs 0 next edge.
- Signed multiply: MULT with rs=-3, rt=7 → md_busy high 33 cycles, EX/MEM bubbles meanwhile, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- Signed divide and divide by zero: DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 10/0 → lo=0xFFFFFFFF, hi=10.
- Start rules: md_start while busy → ignored, result unchanged; md_start with flush in IDLE → md_busy stays 0; MFLO after completion returns lo.
- Async reset at RUN cycle 15 → md_busy=0 immediately, hi=lo=0, and a later MULT completes correctly.
